// File: rtl/ipg_rx_stream_if.sv
// AXI-Stream channel carrying packed IPG side-channel words out of ipg_rx_stream.
interface ipg_rx_stream_if #(
  parameter int OUT_WIDTH = 64
) ();
  logic [OUT_WIDTH-1:0]   tdata;
  logic [OUT_WIDTH/8-1:0] tkeep;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/ipg_rx_stream.sv
// Extracts IPG side-channel bytes from 64b/66b control blocks, zeroes those lanes,
// packs the bytes into OUT_WIDTH words (timeout flush) and buffers them for AXI-Stream.
module ipg_rx_stream #(
  parameter int OUT_WIDTH     = 64,
  parameter int FIFO_DEPTH    = 8,
  parameter int FLUSH_TIMEOUT = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          encoded_rx_valid,
  input  logic [1:0]                    encoded_rx_hdr,
  input  logic [63:0]                   encoded_rx_data,
  output logic                          recovered_encoded_rx_valid,
  output logic [1:0]                    recovered_encoded_rx_hdr,
  output logic [63:0]                   recovered_encoded_rx_data,
  ipg_rx_stream_if.master               m_axis_ipg,
  output logic [15:0]                   stat_overflow_count,
  output logic [15:0]                   stat_bad_block_count,
  output logic [$clog2(FIFO_DEPTH):0]   stat_fifo_level
);
  localparam int NB = OUT_WIDTH / 8;
  localparam int CW = $clog2(NB);
  localparam int TW = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = OUT_WIDTH + NB + 1;
  localparam int BW = 2 * OUT_WIDTH;

  logic [7:0]  lane_mask, blk_mask;
  logic        known_type, is_ctrl, bad_block;
  logic [63:0] lane_zero, ext_bytes;
  logic [3:0]  ext_cnt;

  always_comb begin
    lane_mask  = 8'h00;
    known_type = 1'b1;
    case (encoded_rx_data[7:0])
      8'h1e:                             lane_mask = 8'hfe;
      8'h2d, 8'h33:                      lane_mask = 8'h0e;
      8'h4b, 8'hb4:                      lane_mask = 8'he0;
      8'h87:                             lane_mask = 8'hfc;
      8'h99:                             lane_mask = 8'hf8;
      8'haa:                             lane_mask = 8'hf0;
      8'hcc:                             lane_mask = 8'hc0;
      8'hd2:                             lane_mask = 8'h80;
      8'h66, 8'h55, 8'h78, 8'he1, 8'hff: lane_mask = 8'h00;
      default:                           known_type = 1'b0;
    endcase
  end

  assign is_ctrl   = (encoded_rx_hdr == 2'b01);
  assign blk_mask  = (encoded_rx_valid && is_ctrl) ? lane_mask : 8'h00;
  assign bad_block = encoded_rx_valid &&
                     ((encoded_rx_hdr == 2'b00) || (encoded_rx_hdr == 2'b11) || (is_ctrl && !known_type));

  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_lane
    assign lane_zero[8*gi +: 8] = {8{blk_mask[gi]}};
  end

  // Compact the selected lanes into consecutive bytes, lowest lane first.
  always_comb begin
    ext_bytes = '0;
    ext_cnt   = '0;
    for (int k = 1; k < 8; k++) begin
      if (blk_mask[k]) begin
        ext_bytes[8*ext_cnt +: 8] = encoded_rx_data[8*k +: 8];
        ext_cnt = ext_cnt + 4'd1;
      end
    end
  end

  logic                 rec_valid_reg;
  logic [1:0]           rec_hdr_reg;
  logic [63:0]          rec_data_reg;
  logic [OUT_WIDTH-1:0] acc_data_reg, acc_data_next;
  logic [CW-1:0]        acc_cnt_reg, acc_cnt_next, base_cnt;
  logic [TW-1:0]        tmo_cnt_reg, tmo_cnt_next;
  logic [BW-1:0]        comb_buf;
  logic [CW:0]          total;
  logic [NB-1:0]        flush_keep;
  logic                 flush, full_word, push;
  logic [EW-1:0]        push_word;

  for (gi = 0; gi < NB; gi++) begin : g_keep
    assign flush_keep[gi] = (CW'(gi) < acc_cnt_reg);
  end

  // A flush empties the accumulator first, so new bytes in the same cycle start a fresh word.
  assign flush     = (FLUSH_TIMEOUT != 0) && (acc_cnt_reg != '0) && (tmo_cnt_reg == TW'(FLUSH_TIMEOUT));
  assign base_cnt  = flush ? '0 : acc_cnt_reg;
  assign comb_buf  = BW'(flush ? '0 : acc_data_reg) | (BW'(ext_bytes) << {base_cnt, 3'b000});
  assign total     = {1'b0, base_cnt} + (CW+1)'(ext_cnt);
  assign full_word = (total >= (CW+1)'(NB));
  assign push      = flush || full_word;
  assign push_word = flush ? {1'b1, flush_keep, acc_data_reg}
                           : {1'b0, {NB{1'b1}}, comb_buf[OUT_WIDTH-1:0]};

  always_comb begin
    acc_data_next = full_word ? comb_buf[OUT_WIDTH +: OUT_WIDTH] : comb_buf[OUT_WIDTH-1:0];
    acc_cnt_next  = full_word ? CW'(total - (CW+1)'(NB)) : CW'(total);
    tmo_cnt_next  = tmo_cnt_reg;
    if ((ext_cnt != 4'd0) || flush)
      tmo_cnt_next = '0;
    else if ((acc_cnt_reg != '0) && (tmo_cnt_reg < TW'(FLUSH_TIMEOUT)))
      tmo_cnt_next = tmo_cnt_reg + TW'(1);
  end

  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic [15:0]   ovf_cnt_reg, bad_cnt_reg;
  logic [EW-1:0] head;
  logic          fifo_full, pop, wr_en, drop, out_valid;

  assign out_valid = (level_reg != '0);
  assign fifo_full = (level_reg == LW'(FIFO_DEPTH));
  assign pop       = out_valid && m_axis_ipg.tready;
  assign wr_en     = push && (!fifo_full || pop);
  assign drop      = push && fifo_full && !pop;
  assign head      = fifo_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (wr_en)
      fifo_mem[wr_ptr_reg] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rec_valid_reg <= 1'b0;
      rec_hdr_reg   <= 2'b01;
      rec_data_reg  <= 64'h0000_0000_0000_001e;
      acc_data_reg  <= '0;
      acc_cnt_reg   <= '0;
      tmo_cnt_reg   <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      ovf_cnt_reg   <= '0;
      bad_cnt_reg   <= '0;
    end else begin
      rec_valid_reg <= encoded_rx_valid;
      if (encoded_rx_valid) begin
        rec_hdr_reg  <= encoded_rx_hdr;
        rec_data_reg <= encoded_rx_data & ~lane_zero;
      end
      acc_data_reg <= acc_data_next;
      acc_cnt_reg  <= acc_cnt_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg <= level_reg + LW'(wr_en) - LW'(pop);
      if (drop && (ovf_cnt_reg != 16'hffff))
        ovf_cnt_reg <= ovf_cnt_reg + 16'd1;
      if (bad_block && (bad_cnt_reg != 16'hffff))
        bad_cnt_reg <= bad_cnt_reg + 16'd1;
    end
  end

  assign recovered_encoded_rx_valid = rec_valid_reg;
  assign recovered_encoded_rx_hdr   = rec_hdr_reg;
  assign recovered_encoded_rx_data  = rec_data_reg;
  assign m_axis_ipg.tvalid          = out_valid;
  assign m_axis_ipg.tdata           = out_valid ? head[OUT_WIDTH-1:0] : '0;
  assign m_axis_ipg.tkeep           = out_valid ? head[OUT_WIDTH +: NB] : '0;
  assign m_axis_ipg.tlast           = out_valid && head[EW-1];
  assign stat_overflow_count        = ovf_cnt_reg;
  assign stat_bad_block_count       = bad_cnt_reg;
  assign stat_fifo_level            = level_reg;
endmodule

// File: tb/tb_ipg_rx_stream.sv
// Directed bench for ipg_rx_stream: recovered path checked inline, AXI-Stream words
// checked by a queue-based scoreboard monitor.
module tb_ipg_rx_stream;
  typedef struct packed {
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [1:0]  rx_hdr = 2'b10;
  logic [63:0] rx_data = '0;
  logic        rec_valid;
  logic [1:0]  rec_hdr;
  logic [63:0] rec_data;
  logic [15:0] ovf_cnt, bad_cnt;
  logic [3:0]  level;

  int    n_vec = 0;
  int    n_err = 0;
  int    n_words = 0;
  word_t exp_q[$];
  word_t got_w, exp_w;

  ipg_rx_stream_if #(.OUT_WIDTH(64)) axis ();

  ipg_rx_stream #(.OUT_WIDTH(64), .FIFO_DEPTH(8), .FLUSH_TIMEOUT(32)) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .encoded_rx_valid           (rx_valid),
    .encoded_rx_hdr             (rx_hdr),
    .encoded_rx_data            (rx_data),
    .recovered_encoded_rx_valid (rec_valid),
    .recovered_encoded_rx_hdr   (rec_hdr),
    .recovered_encoded_rx_data  (rec_data),
    .m_axis_ipg                 (axis),
    .stat_overflow_count        (ovf_cnt),
    .stat_bad_block_count       (bad_cnt),
    .stat_fifo_level            (level)
  );

  always #5 clk = ~clk;

  logic [7:0] sw_type [16] = '{8'h1e, 8'h2d, 8'h33, 8'h4b, 8'h87, 8'h99, 8'haa, 8'hb4,
                               8'hcc, 8'hd2, 8'h66, 8'h55, 8'h78, 8'he1, 8'hff, 8'h5a};
  logic [7:0] sw_mask [16] = '{8'hfe, 8'h0e, 8'h0e, 8'he0, 8'hfc, 8'hf8, 8'hf0, 8'he0,
                               8'hc0, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  int         sw_cnt  [16] = '{7, 3, 3, 3, 6, 5, 4, 3, 2, 1, 0, 0, 0, 0, 0, 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Output words are checked whenever a transfer happens on the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && axis.tvalid && axis.tready) begin
        got_w = '{last: axis.tlast, keep: axis.tkeep, data: axis.tdata};
        n_vec++;
        n_words++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_word: got data=%h keep=%h last=%b, required no word",
                   got_w.data, got_w.keep, got_w.last);
        end else begin
          exp_w = exp_q.pop_front();
          if (got_w !== exp_w) begin
            n_err++;
            $display("FAIL word%0d: got data=%h keep=%h last=%b required data=%h keep=%h last=%b",
                     n_words, got_w.data, got_w.keep, got_w.last, exp_w.data, exp_w.keep, exp_w.last);
          end else begin
            $display("word %0d: data=%h keep=%h last=%b ok", n_words, got_w.data, got_w.keep, got_w.last);
          end
        end
      end
    end
  end

  task automatic send(input string tag, input logic [1:0] h, input logic [63:0] d, input logic [63:0] er);
    rx_valid = 1'b1;
    rx_hdr   = h;
    rx_data  = d;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    chk({tag, ".rec_valid"}, 64'(rec_valid), 64'd1);
    chk({tag, ".rec_hdr"}, 64'(rec_hdr), 64'(h));
    chk({tag, ".rec_data"}, rec_data, er);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] zero_lanes(input logic [63:0] d, input logic [7:0] m);
    logic [63:0] r = d;
    for (int k = 0; k < 8; k++)
      if (m[k]) r[8*k +: 8] = 8'h00;
    return r;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, ".rec_valid"}, 64'(rec_valid), 64'd0);
    chk({tag, ".rec_hdr"}, 64'(rec_hdr), 64'd1);
    chk({tag, ".rec_data"}, rec_data, 64'h1e);
    chk({tag, ".tvalid"}, 64'(axis.tvalid), 64'd0);
    chk({tag, ".tdata"}, axis.tdata, 64'd0);
    chk({tag, ".tkeep"}, 64'(axis.tkeep), 64'd0);
    chk({tag, ".tlast"}, 64'(axis.tlast), 64'd0);
    chk({tag, ".overflow"}, 64'(ovf_cnt), 64'd0);
    chk({tag, ".bad_block"}, 64'(bad_cnt), 64'd0);
    chk({tag, ".level"}, 64'(level), 64'd0);
  endtask

  initial begin
    int          pend;
    logic [63:0] d, w;

    axis.tready = 1'b1;
    idle(3);
    check_reset_values("reset");
    rst_n = 1'b1;
    idle(1);

    // Idle stream: two 0x1e blocks complete one word, six bytes remain and later time out.
    send("idle_a", 2'b01, 64'h0706050403020100 | 64'h1e, 64'h1e);
    send("idle_b", 2'b01, 64'h0e0d0c0b0a09081e, 64'h1e);
    chk("idle.tvalid_latency", 64'(axis.tvalid), 64'd1);
    exp_q.push_back('{last: 1'b0, keep: 8'hff, data: 64'h0807060504030201});
    exp_q.push_back('{last: 1'b1, keep: 8'h3f, data: 64'h00000e0d0c0b0a09});
    idle(40);
    chk("idle.rec_valid_drop", 64'(rec_valid), 64'd0);

    // Per-type sweep with every lane carrying 0xAA.
    pend = 0;
    for (int i = 0; i < 16; i++) begin
      d = {56'hAAAAAAAAAAAAAA, sw_type[i]};
      send($sformatf("sweep_%h", sw_type[i]), 2'b01, d, zero_lanes(d, sw_mask[i]));
      pend += sw_cnt[i];
      if (pend >= 8) begin
        exp_q.push_back('{last: 1'b0, keep: 8'hff, data: 64'hAAAAAAAAAAAAAAAA});
        pend -= 8;
      end
    end
    chk("sweep.bad_block", 64'(bad_cnt), 64'd1);
    send("data_blk", 2'b10, 64'hAAAAAAAAAAAAAA1e, 64'hAAAAAAAAAAAAAA1e);
    chk("data_blk.bad_block", 64'(bad_cnt), 64'd1);
    chk("sweep.pending", 64'(pend), 64'd5);
    exp_q.push_back('{last: 1'b1, keep: 8'h1f, data: 64'h000000AAAAAAAAAA});
    idle(40);

    // Timeout: partial word lands exactly FLUSH_TIMEOUT+1 edges after the block.
    send("tmo_2d", 2'b01, 64'h776655443322112d, 64'h776655440000002d);
    exp_q.push_back('{last: 1'b1, keep: 8'h07, data: 64'h0000000000332211});
    idle(32);
    chk("tmo.tvalid_early", 64'(axis.tvalid), 64'd0);
    idle(1);
    chk("tmo.tvalid_flush", 64'(axis.tvalid), 64'd1);
    idle(5);

    // Backpressure: 10 words into an 8-deep FIFO, last two dropped.
    axis.tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      w = '0;
      for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(16*i + k + 1);
      send("bp_1e", 2'b01, {w[55:0], 8'h1e}, 64'h1e);
      d = {w[63:56], 48'h5c5c5c5c5c5c, 8'hd2};
      send("bp_d2", 2'b01, d, {8'h00, d[55:0]});
      if (i < 8) exp_q.push_back('{last: 1'b0, keep: 8'hff, data: w});
    end
    chk("bp.level_full", 64'(level), 64'd8);
    chk("bp.overflow", 64'(ovf_cnt), 64'd2);
    idle(3);
    chk("bp.tdata_hold", axis.tdata, 64'h0807060504030201);
    axis.tready = 1'b1;
    idle(4);
    chk("bp.level_half", 64'(level), 64'd4);
    idle(4);
    chk("bp.level_empty", 64'(level), 64'd0);
    chk("bp.tvalid_empty", 64'(axis.tvalid), 64'd0);

    // Header errors pass the payload through untouched.
    send("hdr00", 2'b00, 64'h0123456789abcd1e, 64'h0123456789abcd1e);
    chk("hdr00.bad_block", 64'(bad_cnt), 64'd2);
    send("hdr11", 2'b11, 64'hfedcba98765432aa, 64'hfedcba98765432aa);
    chk("hdr11.bad_block", 64'(bad_cnt), 64'd3);
    idle(2);
    chk("hdr.level", 64'(level), 64'd0);

    // Reset mid-stream with 3 queued words and 5 pending bytes.
    axis.tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send("rst_1e", 2'b01, 64'h313131313131311e, 64'h1e);
      send("rst_d2", 2'b01, 64'h32000000000000d2, 64'h00000000000000d2);
    end
    send("rst_99", 2'b01, 64'h8786858483828199, 64'h0000000000828199);
    chk("rst.level_before", 64'(level), 64'd3);
    rst_n = 1'b0;
    idle(1);
    check_reset_values("midreset");
    rst_n = 1'b1;
    axis.tready = 1'b1;
    idle(60);
    chk("rst.no_flush_tvalid", 64'(axis.tvalid), 64'd0);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("scoreboard.drained", 64'(exp_q.size()), 64'd0);
    chk("scoreboard.word_count", 64'(n_words), 64'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ipg_rx_stream.md
# ipg_rx_stream

Parametrised successor to the per-block IPG extractor on the 64b/66b receive path. It pulls side-channel bytes hidden in the idle/control lanes of received control blocks and zeroes those lanes, so downstream PCS decode sees plain idles. It also packs the extracted bytes into fixed-width words with partial-word timeout flush, and delivers them through a buffered AXI-Stream master. Sits between the PHY RX gearbox/descrambler and the PCS decoder.

## Interface
- OUT_WIDTH, 64: output word width in bits; multiple of 8, ≥64.
- FIFO_DEPTH, 8: output FIFO depth in words; power of 2, ≥2.
- FLUSH_TIMEOUT, 32: idle cycles before a partial word is flushed; 0 disables flushing.
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active low.
- encoded_rx_valid  in  1  input block valid (gearbox may stall).
- encoded_rx_hdr  in  2  sync header.
- encoded_rx_data  in  64  block payload, block type in [7:0].
- recovered_encoded_rx_valid  out  1  registered copy of encoded_rx_valid.
- recovered_encoded_rx_hdr  out  2  header, passed unchanged.
- recovered_encoded_rx_data  out  64  payload with IPG lanes zeroed.
- m_axis_ipg_tdata  out  OUT_WIDTH  packed IPG bytes; byte 0 in [7:0].
- m_axis_ipg_tkeep  out  OUT_WIDTH/8  valid byte lanes.
- m_axis_ipg_tlast  out  1  set on a timeout-flushed partial word.
- m_axis_ipg_tvalid  out  1  word available.
- m_axis_ipg_tready  in  1  consumer accepts.
- stat_overflow_count  out  16  words dropped on full FIFO; saturating.
- stat_bad_block_count  out  16  bad headers / unknown control types; saturating.
- stat_fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- A block is processed only when encoded_rx_valid=1. Non-valid cycles change nothing except the timeout counter.
- Lane extraction applies only when hdr=2'b01. Lane k = data[8k+7:8k].
  - 0x1e: lanes 1–7.
  - 0x2d, 0x33: lanes 1–3.
  - 0x4b: lanes 5–7.
  - 0x87: lanes 2–7.
  - 0x99: lanes 3–7.
  - 0xaa: lanes 4–7.
  - 0xb4: lanes 5–7.
  - 0xcc: lanes 6–7.
  - 0xd2: lane 7.
  - 0x66, 0x55, 0x78, 0xe1, 0xff: no lanes.
  - Any other type: no lanes, bad_block +1.
- hdr 2'b00 or 2'b11: no extraction, payload passed unchanged, bad_block +1.
- hdr 2'b10 (data block): passed unchanged.
- Extracted lanes are zeroed in recovered_encoded_rx_data. All other bits, the header and valid are copied unchanged.
- Packing: extracted bytes are appended in ascending lane order to a byte accumulator.
  - acc_cnt is the number of pending bytes, range 0..OUT_WIDTH/8−1.
  - If acc_cnt+n ≥ OUT_WIDTH/8, the lowest OUT_WIDTH/8 bytes form a full word (tkeep all ones, tlast=0) and the remaining bytes stay pending.
  - At most one word is produced per block.
- Timeout: the counter clears whenever bytes are appended and increments each cycle while acc_cnt>0. When it reaches FLUSH_TIMEOUT:
  - a partial word is emitted: tkeep low acc_cnt bits set, unused bytes zero, tlast=1;
  - acc_cnt→0 and the counter clears.
- FIFO write with FIFO full: the word is dropped, overflow +1, and the accumulator still advances. Simultaneous push and pop at full is allowed and counts as not full.
- Reset values:
  - recovered_encoded_rx_valid 0, hdr 2'b01, data 64'h0000_0000_0000_001e.
  - tvalid 0, tdata 0, tkeep 0, tlast 0.
  - Both stat counters 0, stat_fifo_level 0.
  - Accumulator empty, timeout counter 0, FIFO empty.
- Reset asserted mid-stream discards pending bytes and FIFO contents immediately. No flush is emitted.

## Timing
- Recovered path latency: 1 cycle, registered, full throughput.
- A word completed by a block in cycle N is written to the FIFO at the end of cycle N. With an empty FIFO, tvalid=1 in cycle N+1.
- The timeout flush word is written in the cycle the counter equals FLUSH_TIMEOUT; tvalid follows 1 cycle later.
- AXI-Stream rules:
  - tdata/tkeep/tlast are held stable while tvalid=1 and tready=0.
  - A transfer occurs when tvalid=1 and tready=1 on a clock edge.
  - Back-to-back transfers are supported at 1 word/cycle.
- Stat counters update 1 cycle after the causing block.

## Test plan
- Idle stream: 0x1e blocks with lanes 1–7 = 01..07, then 0x1e with 08..0e → recovered data 64'h1e each, 1-cycle delay. One word 64'h0807060504030201 with tkeep 0xff, tlast 0. Bytes 09..0e remain pending.
- Per-type sweep: each listed type with lanes filled with 0xAA → correct lanes zeroed and byte counts 7,3,3,3,6,5,4,3,2,1,0. Type 0x5a increments stat_bad_block_count to 1 with no extraction.
- Timeout: one 0x2d block with bytes 11,22,33, then 32 idle cycles → partial word 64'h332211, tkeep 0x07, tlast 1.
- Backpressure: tready=0 and enough blocks for 10 full words with FIFO_DEPTH=8 → stat_fifo_level=8, overflow_count=2. Raising tready drains the first 8 words in order, 1 per cycle.
- Header errors: hdr 2'b00 then 2'b11 → payload unchanged, bad_block_count=2.
- Reset mid-stream: rst_n=0 with 5 bytes pending and 3 FIFO words → all outputs at reset values next cycle, and no flush word is emitted after release.
